stack_req_sequencer: RTL

- Upstream front-end for the push-down stack. Accepts push/pop/peek requests on a valid/ready handshake and checks them against the stack's empty/full flags.
- Drives the stack's single-cycle PushPop/En/data command and returns read data plus an error flag on a valid/ready response channel.
- Guarantees the stack never sees push-when-full, pop-when-empty or a multi-cycle En pulse.

---
 rtl/stack_req_sequencer.sv | 103 ++++++++++
 1 files changed

// File: rtl/stack_req_sequencer.sv
// stack_req_sequencer: valid/ready front-end issuing guarded single-cycle push/pop/peek commands to a stack.
// Optional STACK_SEQ_DEPTH_EN adds a shadow depth counter (depth_o) and a registered depth_mismatch_o flag.
module stack_req_sequencer #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 10
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [1:0]           req_op_i,
    input  logic [DATAWIDTH-1:0] req_data_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [DATAWIDTH-1:0] resp_data_o,
    output logic                 resp_err_o,
    output logic                 stk_pushpop_o,
    output logic                 stk_en_o,
    output logic [DATAWIDTH-1:0] stk_data_o,
    input  logic [DATAWIDTH-1:0] stk_data_i,
`ifdef STACK_SEQ_DEPTH_EN
    output logic [ADDRWIDTH:0]   depth_o,
    output logic                 depth_mismatch_o,
`endif
    input  logic                 stk_empty_i,
    input  logic                 stk_full_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t state, next;
    logic [1:0] op_q;
    logic [DATAWIDTH-1:0] data_q;
    logic empty, full, ok, is_push, is_pop;

    assign is_push = op_q == 2'b00;
    assign is_pop = op_q == 2'b01;
    assign ok = is_push ? !full : (op_q != 2'b11) && !empty;
    assign stk_data_o = data_q;

`ifdef STACK_SEQ_DEPTH_EN
    assign empty = depth_o == '0;
    assign full = depth_o == {1'b0, {ADDRWIDTH{1'b1}}};
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            depth_o <= '0;
            depth_mismatch_o <= 1'b0;
        end else begin
            depth_mismatch_o <= (depth_o == '0) != stk_empty_i;
            if (stk_en_o) depth_o <= stk_pushpop_o ? depth_o - 1'b1 : depth_o + 1'b1;
        end
`else
    assign empty = stk_empty_i;
    assign full = stk_full_i;
`endif

    always_ff @(posedge Clk or posedge Rst)
        if (Rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        req_ready_o = 1'b0;
        resp_valid_o = 1'b0;
        stk_en_o = 1'b0;
        stk_pushpop_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = !Rst;
                next = req_valid_i ? ISSUE : IDLE;
            end
            ISSUE: begin
                stk_en_o = ok && (is_push || is_pop);
                stk_pushpop_o = is_pop;
                next = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                next = resp_ready_i ? IDLE : RESP;
            end
            default: next = IDLE;
        endcase
    end

    // stk_data_i is the top element before this cycle's pop takes effect
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            op_q <= 2'b00;
            data_q <= '0;
            resp_data_o <= '0;
            resp_err_o <= 1'b0;
        end else begin
            if (state == IDLE && req_valid_i) begin
                op_q <= req_op_i;
                if (req_op_i == 2'b00) data_q <= req_data_i;
            end
            if (state == ISSUE) begin
                resp_data_o <= (ok && !is_push) ? stk_data_i : '0;
                resp_err_o <= !ok;
            end else if (state == RESP && resp_ready_i) begin
                resp_data_o <= '0;
                resp_err_o <= 1'b0;
            end
        end
endmodule
